// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX FIFO write port between NUM_REQ byte
// producers. Round-robin arbitration with burst locking keeps each message
// contiguous in the FIFO. A grant is released on a last beat or after
// MAX_BURST beats, whichever comes first.
// Optional build macro: UART_TX_ARB_PRIO0_EN gives requester 0 absolute
// priority at arbitration time; the remaining requesters stay round-robin.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      TX_full,
  output logic                      TX_wr,
  output logic [DATA_W-1:0]         TX_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   cnt_inc;

  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   release_ptr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;
  logic               beat;

  // Round-robin scan starting at rr_ptr; first valid requester wins
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
`ifdef UART_TX_ARB_PRIO0_EN
      if (!found && req_valid[cand] && (cand != '0)) begin
`else
      if (!found && req_valid[cand]) begin
`endif
        found = 1'b1;
        pick  = cand;
      end
    end
`ifdef UART_TX_ARB_PRIO0_EN
    if (req_valid[0]) begin
      found = 1'b1;
      pick  = '0;
    end
`endif
  end

  // Granted requester's byte, last flag and the pointer to resume from
  always_comb begin
    sel_data    = '0;
    release_ptr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data    = req_data[i*DATA_W +: DATA_W];
        release_ptr = PTR_W'((i + 1) % NUM_REQ);
      end
    end
    sel_last = |(grant_q & req_last);
  end

  // Handshake and FIFO write, combinational from the held grant
  always_comb begin
    req_ready = grant_q & {NUM_REQ{~TX_full}};
    beat      = |(req_valid & req_ready);
    TX_wr     = beat;
    TX_wdata  = beat ? sel_data : '0;
  end

  // Next-state: grant on arbitration, count beats, release on last or burst cap
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    cnt_inc    = beat_cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = NUM_REQ'(1) << pick;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (beat) begin
          beat_cnt_d = cnt_inc;
          if (sel_last || (cnt_inc == BURST_MAX)) begin
            grant_d    = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = release_ptr;
            state_d    = ST_IDLE;
          end
        end
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_LOCK);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART TX FIFO write port (TX_wr / TX_wdata / TX_full) between NUM_REQ independent byte producers, e.g. the APB FIFO peripheral and a stopwatch/clock status reporter.
- Arbitration is round-robin with burst locking, so a requester's message (up to req_last or MAX_BURST bytes) reaches the FIFO contiguous and never interleaved with another requester's bytes.
- Sits between the producers and TOP_UART_Stopwatch_Clock TX FIFO, in the PCLK domain.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 8, byte width written to TX FIFO
MAX_BURST, 16, max beats per grant before forced release (1..255)

Ports:
PCLK  in  1  system clock, rising edge
PRESET  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  requester i has a byte on its data slice
req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  current byte of requester i ends its message
req_ready  out  NUM_REQ  byte of requester i accepted this cycle when valid&ready
TX_full  in  1  TX FIFO full
TX_wr  out  1  TX FIFO write strobe
TX_wdata  out  DATA_W  TX FIFO write data
grant  out  NUM_REQ  one-hot current owner, all zero when idle
busy  out  1  a grant is held

Behaviour:
- One clock PCLK; reset PRESET is synchronous and active-high. On reset: state=IDLE, grant=0, busy=0, rr_ptr=0, beat_cnt=0. Outputs req_ready=0 and TX_wr=0 follow combinationally from the cleared state.
- States:
  - IDLE: scan requesters starting at rr_ptr, wrapping modulo NUM_REQ. The first i with req_valid[i]=1 is registered into grant (one-hot); next state LOCK. With no valid requester, stay in IDLE.
  - LOCK: busy=1. req_ready[g]=!TX_full for the granted g; req_ready=0 for all other requesters.
- Beat: a beat occurs when req_valid[g] && req_ready[g]. Both TX_wr and TX_wdata are combinational:
  - TX_wr = beat.
  - TX_wdata = granted slice, or 0 when no beat.
- Latency: 1 cycle from req_valid rising in IDLE to grant; data reaches TX_wr in the same cycle as the handshake.
- beat_cnt increments on every beat and is 8 bits wide.
- Release happens on a beat with req_last[g]=1, or on the beat that makes beat_cnt==MAX_BURST. On release:
  - grant=0, beat_cnt=0, rr_ptr=(g+1) mod NUM_REQ, next state IDLE.
  - Releasing always costs one IDLE cycle, so max throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- TX_full=1: no beat occurs, the grant is held, and there is no timeout. The requester must keep req_valid/data/last stable while ready=0.
- If req_valid[g] drops during LOCK, the grant is held until the message ends; other requesters remain blocked.
- Simultaneous requests in IDLE: the lowest index at or after rr_ptr wins. Example: with rr_ptr=1 and both 0 and 1 valid, 1 wins.
- Reset asserted mid-burst: the next edge forces IDLE, and the in-flight message is truncated. TX_wr=0 from that edge onward.
- At most one TX_wr per cycle, and never while TX_full=1, so the arbiter never overflows the FIFO.

Optional Feature:
- Macro UART_TX_ARB_PRIO0_EN.
- Defined: in IDLE, requester 0 wins whenever req_valid[0]=1, regardless of rr_ptr. Other requesters are round-robin among themselves. An active burst is never preempted.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, then req_valid[0]=1 with bytes 0x41,0x42,0x43 (last on 0x43) and TX_full=0 -> grant=01 on the next cycle. TX_wr is high for 3 consecutive cycles with data 41,42,43, then IDLE with grant=0 and rr_ptr=1.
- Both requesters continuously valid, messages of 2 bytes each (req0: A0,A1; req1: B0,B1) -> FIFO sees A0 A1 B0 B1 A0 A1..., with one idle cycle between bursts and no interleaving.
- req1 streams 20 bytes with no last, MAX_BURST=16 -> release after the 16th byte. With req0 waiting, req0 is granted next; req1 resumes at byte 17 afterwards.
- TX_full=1 for 5 cycles mid-burst -> req_ready=0 and TX_wr=0 for those 5 cycles, grant is held, and the byte presented at stall is written on the first cycle TX_full=0.
- PRESET pulsed for 1 cycle during the 2nd beat of a burst -> the next cycle shows grant=0, busy=0, TX_wr=0, and rr_ptr=0, so req0 wins the next arbitration.
- With UART_TX_ARB_PRIO0_EN, rr_ptr=1, and req0 and req1 valid together in IDLE -> req0 is granted. Without the macro, req1 is granted.
